// File: rtl/program_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_if
// Description : Sequencer-side control and status bundle for program_counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_counter_if #(
  parameter int ADDR_W = 6
);
  logic              en;
  logic              ls;
  logic              inc;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc_out;
  logic              stk_empty;
  logic              stk_full;
  logic              stk_err;

  // Sequencer side: issues the control word, observes PC and stack status.
  modport master (
    output en, ls, inc, call, ret,
    input  pc_out, stk_empty, stk_full, stk_err
  );

  // Program counter side.
  modport slave (
    input  en, ls, inc, call, ret,
    output pc_out, stk_empty, stk_full, stk_err
  );
endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : 6-bit PC with increment, jump and CALL/RET return stack,
//               driving the shared address bus. Define PC_TRAP_EN to redirect
//               stack faults to TRAP_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
  parameter int ADDR_W      = 6,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4,
  parameter int TRAP_ADDR   = 63
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [ADDR_W-1:0] addrBUS,
  program_counter_if.slave  ctl
);

  localparam int c_IDX_W = $clog2(STACK_DEPTH);
  localparam int c_SP_W  = c_IDX_W + 1;

`ifdef PC_TRAP_EN
  localparam bit c_TRAP_EN = 1'b1;
`else
  localparam bit c_TRAP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] c_TRAP_PC  = ADDR_W'(TRAP_ADDR);
  localparam logic [c_SP_W-1:0] c_SP_FULL  = c_SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [c_SP_W-1:0]  r_sp;
  logic               r_err;
  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

  logic               w_empty;
  logic               w_full;
  logic [c_IDX_W-1:0] w_push_idx;
  logic [c_IDX_W-1:0] w_top_idx;

  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == c_SP_FULL);
  assign w_push_idx = r_sp[c_IDX_W-1:0];
  assign w_top_idx  = r_sp[c_IDX_W-1:0] - c_IDX_W'(1);

  assign addrBUS       = ctl.en ? r_pc : {ADDR_W{1'bz}};
  assign ctl.pc_out    = r_pc;
  assign ctl.stk_empty = w_empty;
  assign ctl.stk_full  = w_full;
  assign ctl.stk_err   = r_err;

  // Bus loads are suppressed while the PC itself owns the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= c_RESET_PC;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else if (ctl.ret) begin
      if (w_empty) begin
        r_err <= 1'b1;
        if (c_TRAP_EN) begin
          r_pc <= c_TRAP_PC;
        end
      end else begin
        r_sp <= r_sp - c_SP_W'(1);
        r_pc <= r_stack[w_top_idx];
      end
    end else if (ctl.call) begin
      if (!ctl.en) begin
        if (w_full) begin
          r_err <= 1'b1;
          r_pc  <= c_TRAP_EN ? c_TRAP_PC : addrBUS;
        end else begin
          r_stack[w_push_idx] <= r_pc;
          r_sp                <= r_sp + c_SP_W'(1);
          r_pc                <= addrBUS;
        end
      end
    end else if (ctl.ls) begin
      if (!ctl.en) begin
        r_pc <= addrBUS;
      end
    end else if (ctl.inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

endmodule
`default_nettype wire
